// File: rtl/airplane_draw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : airplane_draw_ctrl
//  Purpose  : Erase-then-draw sequencer for the airplane sprite datapath and
//             the VGA plot strobe.
//  Revision : 1.0
// ============================================================================
module airplane_draw_ctrl #(
    parameter int         SIDE     = 4,
    parameter logic [2:0] BG_COLOR = 3'b000,
    parameter int         X_MAX    = 316,
    parameter int         Y_MAX    = 236
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [8:0] new_x,
    input  logic [7:0] new_y,
    input  logic [2:0] new_color,
    output logic       ready,
    output logic       done,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_color,
    output logic [8:0] x_load,
    output logic [7:0] y_load,
    output logic [2:0] color_load,
    output logic       dp_enable,
    output logic       plot
);

    localparam int c_NPIX = SIDE * SIDE;
    localparam int c_CW   = (c_NPIX > 1) ? $clog2(c_NPIX) : 1;
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(c_NPIX - 1);
    localparam logic [8:0]      c_X_MAX = 9'(X_MAX);
    localparam logic [7:0]      c_Y_MAX = 8'(Y_MAX);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_E = 3'd1;
    localparam logic [2:0] S_ERASE  = 3'd2;
    localparam logic [2:0] S_LOAD_D = 3'd3;
    localparam logic [2:0] S_DRAW   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_count;
    logic            r_has_old;
    logic [8:0]      r_old_x;
    logic [7:0]      r_old_y;
    logic [8:0]      r_req_x;
    logic [7:0]      r_req_y;
    logic [2:0]      r_req_c;

    logic            w_accept;
    logic            w_last;
    logic [8:0]      w_clamp_x;
    logic [7:0]      w_clamp_y;

    assign w_accept  = start && (r_state == S_IDLE);
    assign w_last    = (r_count == c_LAST);
    assign w_clamp_x = (new_x > c_X_MAX) ? c_X_MAX : new_x;
    assign w_clamp_y = (new_y > c_Y_MAX) ? c_Y_MAX : new_y;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_has_old <= 1'b0;
            r_old_x   <= '0;
            r_old_y   <= '0;
            r_req_x   <= '0;
            r_req_y   <= '0;
            r_req_c   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_x <= w_clamp_x;
                        r_req_y <= w_clamp_y;
                        r_req_c <= new_color;
                        r_state <= r_has_old ? S_LOAD_E : S_LOAD_D;
                    end
                end
                S_LOAD_E: r_state <= S_ERASE;
                S_ERASE: begin
                    r_count <= r_count + c_CW'(1);
                    if (w_last) begin
                        r_count <= '0;
                        r_state <= S_LOAD_D;
                    end
                end
                S_LOAD_D: r_state <= S_DRAW;
                S_DRAW: begin
                    r_count <= r_count + c_CW'(1);
                    if (w_last) begin
                        // The drawn position becomes the one to erase next time.
                        r_old_x   <= r_req_x;
                        r_old_y   <= r_req_y;
                        r_has_old <= 1'b1;
                        r_count   <= '0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready      = 1'b0;
        done       = 1'b0;
        ld_x       = 1'b0;
        ld_y       = 1'b0;
        ld_color   = 1'b0;
        x_load     = '0;
        y_load     = '0;
        color_load = '0;
        dp_enable  = 1'b0;
        case (r_state)
            S_IDLE: ready = 1'b1;
            S_LOAD_E: begin
                ld_x       = 1'b1;
                ld_y       = 1'b1;
                ld_color   = 1'b1;
                x_load     = r_old_x;
                y_load     = r_old_y;
                color_load = BG_COLOR;
            end
            S_LOAD_D: begin
                ld_x       = 1'b1;
                ld_y       = 1'b1;
                ld_color   = 1'b1;
                x_load     = r_req_x;
                y_load     = r_req_y;
                color_load = r_req_c;
            end
            S_ERASE, S_DRAW: dp_enable = 1'b1;
            S_DONE:  done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign plot = dp_enable;

endmodule
`default_nettype wire

// File: tb/tb_airplane_draw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_airplane_draw_ctrl
//  Purpose  : Scoreboard bench for airplane_draw_ctrl using directed moves.
//  Revision : 1.0
// ============================================================================
module tb_airplane_draw_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] new_x = '0;
    logic [7:0] new_y = '0;
    logic [2:0] new_color = '0;
    logic       ready, done, ld_x, ld_y, ld_color, dp_enable, plot;
    logic [8:0] x_load;
    logic [7:0] y_load;
    logic [2:0] color_load;

    airplane_draw_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .new_x      (new_x),
        .new_y      (new_y),
        .new_color  (new_color),
        .ready      (ready),
        .done       (done),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .ld_color   (ld_color),
        .x_load     (x_load),
        .y_load     (y_load),
        .color_load (color_load),
        .dp_enable  (dp_enable),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        int is_done;
        int x;
        int y;
        int c;
        int cyc;
        int plots;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  plots_seen = 0;
    bit  m_has_old = 0;
    int  m_ox = 0;
    int  m_oy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every load or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ready) plots_seen = 0;
            if (ld_x || ld_y || ld_color || done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got ld=%b%b%b done=%b at cycle %0d expected none",
                             ld_x, ld_y, ld_color, done, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("event_kind", int'(done), mon_e.is_done);
                    chk("plots_before", plots_seen, mon_e.plots);
                    if (mon_e.is_done != 0) begin
                        chk("done_no_ld", int'({ld_x, ld_y, ld_color}), 0);
                        chk("done_loads_zero", int'({x_load, y_load, color_load}), 0);
                    end else begin
                        chk("ld_all", int'({ld_x, ld_y, ld_color}), 7);
                        chk("ld_no_plot", int'({plot, dp_enable}), 0);
                        chk("x_load", int'(x_load), mon_e.x);
                        chk("y_load", int'(y_load), mon_e.y);
                        chk("color_load", int'(color_load), mon_e.c);
                    end
                end
                plots_seen = 0;
            end else if (plot) begin
                plots_seen++;
            end
        end
    end

    task automatic do_req(input int x, input int y, input int c, input bit hold);
        int  a, cx, cy;
        bit  ok;
        new_x     = 9'(x);
        new_y     = 8'(y);
        new_color = 3'(c);
        start     = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ready) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 200 cycles");
            start = 1'b0;
            return;
        end
        a  = cyc;
        cx = (x > 316) ? 316 : x;
        cy = (y > 236) ? 236 : y;
        if (m_has_old) begin
            exp_q.push_back('{0, m_ox, m_oy, 0, a + 1, 0});
            exp_q.push_back('{0, cx, cy, c, a + 18, 16});
            exp_q.push_back('{1, 0, 0, 0, a + 35, 16});
        end else begin
            exp_q.push_back('{0, cx, cy, c, a + 1, 0});
            exp_q.push_back('{1, 0, 0, 0, a + 18, 16});
        end
        m_has_old = 1;
        m_ox = cx;
        m_oy = cy;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        chk("ready_after_done", int'(ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        exp_q.delete();
        m_has_old = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_ld", int'({ld_x, ld_y, ld_color}), 0);
        chk("rst_plot", int'({plot, dp_enable}), 0);
        chk("rst_loads", int'({x_load, y_load, color_load}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First move: no erase pass
        do_req(10, 20, 4, 0);
        wait_idle();

        // Second move: erase old then draw new
        do_req(50, 60, 2, 0);
        wait_idle();

        // Out-of-range origin is clamped
        do_req(400, 250, 1, 0);
        wait_idle();

        // start pulsed during ERASE must be ignored
        do_req(5, 6, 7, 0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        new_x = 9'd100;
        @(negedge clk);
        chk("ready_in_erase", int'(ready), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset in the middle of DRAW (count 7)
        do_req(30, 40, 3, 0);
        repeat (25) @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_done", int'(done), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_has_old = 0;

        // After abort, the next request takes the no-erase path
        do_req(7, 8, 5, 0);
        wait_idle();

        // start held high across three requests
        pulse_reset();
        do_req(11, 12, 1, 1);
        do_req(13, 14, 2, 1);
        do_req(15, 16, 3, 1);
        start = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
